vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Single-port framebuffer arbiter between the VGA scan-out path and a pixel-write requester. It consumes the horizontal and vertical scan positions from the VGA sync generators. During the active region it owns the RAM port for display fetches and returns pixels with fixed latency. Pixel writes are buffered in a small FIFO and drained into the RAM only in blanking cycles, so display reads are never stalled or corrupted.

## Interface
- COUNTER_SIZE, 11, width of h_pos/v_pos
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- ADDR_WIDTH, 19, framebuffer address width (must hold H_ACTIVE*V_ACTIVE-1)
- DATA_WIDTH, 8, pixel width
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)

Ports:
- control_clock  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- h_pos  input  COUNTER_SIZE  current horizontal scan position
- v_pos  input  COUNTER_SIZE  current vertical scan position
- wr_valid  input  1  write request valid
- wr_ready  output  1  FIFO can accept; transfer on wr_valid&&wr_ready
- wr_addr  input  ADDR_WIDTH  pixel address for write
- wr_data  input  DATA_WIDTH  pixel value for write
- wr_err  output  1  one-cycle pulse: popped write had out-of-range address, discarded
- mem_addr  output  ADDR_WIDTH  RAM address (registered)
- mem_we  output  1  RAM write enable (registered)
- mem_wdata  output  DATA_WIDTH  RAM write data (registered)
- mem_rdata  input  DATA_WIDTH  RAM read data, synchronous RAM, one-cycle read latency
- pix_data  output  DATA_WIDTH  display pixel
- pix_valid  output  1  pix_data belongs to the active region

## Operation
- Each cycle: active = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE); drain_ok per Configuration.
- Port-owner FSM, states IDLE, FETCH, WRITE; it is registered and selects the owner of the RAM port for the next cycle:
  - active → FETCH: mem_addr = v_pos*H_ACTIVE + h_pos (computed at ADDR_WIDTH, truncated), mem_we=0.
  - !active && drain_ok && FIFO non-empty → WRITE: pop head; if head addr < H_ACTIVE*V_ACTIVE, drive mem_we=1, mem_addr/mem_wdata = head; otherwise mem_we=0, wr_err=1.
  - else → IDLE: mem_we=0, mem_addr holds its previous value.
- Display always wins. A write is never issued in a cycle where active=1.
- FIFO: wr_ready = !full. Push on handshake, pop only in WRITE decision. Simultaneous push and pop when not full: both occur, level unchanged. When full, no push in the same cycle even if popping.
- Writes are committed in FIFO order. No write coalescing.
- pix_valid is the 3-cycle-delayed active flag. pix_data = mem_rdata when delayed active=1, else 0.

## Timing
- Fetch pipeline: h_pos/v_pos sampled in cycle t → mem_addr valid t+1 → mem_rdata valid t+2 → pix_data/pix_valid valid t+3. Latency is fixed at 3 cycles with no bubbles inside the active region.
- Write: a handshake in cycle t reaches the FIFO at t+1. With drain_ok and an empty FIFO, mem_we is asserted at t+2 at the earliest.
- Drain throughput: one write per eligible cycle.
- wr_err is asserted in the same cycle the dropped entry would have driven mem_we.
- Reset (async assert, synchronous deassert is external): FSM=IDLE, FIFO empty, wr_ready=0 while reset_n=0 and 1 on the first cycle after release, mem_we=0, mem_addr=0, mem_wdata=0, pix_data=0, pix_valid=0, wr_err=0.
- Reset mid-drain: all buffered writes are lost, and no partial mem_we pulse is produced.
- Wrap-around: positions beyond the active limits only affect the active flag. The block does not count positions itself.

## Configuration
- VGA_FB_HBLANK_WRITE_EN defined: drain_ok = 1, so writes drain in any non-active cycle, including horizontal blanking within visible lines.
- Undefined: drain_ok = (v_pos >= V_ACTIVE), so writes drain only during vertical blanking and horizontal-blanking cycles of visible lines are IDLE.

## Test plan
- Reset release with h_pos=0, v_pos=0, RAM preloaded with addr value = addr[7:0] → pix_valid rises at cycle 3, pix_data sequence 0x00,0x01,0x02… with no gaps across the 640-pixel line.
- h_pos=100, v_pos=2 → mem_addr=1380 one cycle later; pix_data=RAM[1380] three cycles after sampling.
- Push 4 writes (addr 10..13, data 0xA0..0xA3) during an active line → wr_ready=0 after the 4th, mem_we stays 0 until blanking, then 4 consecutive writes in order.
- Push a write with addr=307200 during blanking → mem_we stays 0, wr_err pulses once, next FIFO entry writes normally.
- Write at h_pos=700, v_pos=5: with VGA_FB_HBLANK_WRITE_EN it commits within the same hblank; without the macro it waits until v_pos=480.
- Assert reset_n=0 with 3 entries queued during vblank → mem_we=0 immediately, FIFO empty after release, no stale writes occur.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter; display fetches own the RAM in the active region, buffered pixel writes drain in blanking
// Ports:
//   control_clock, reset_n              : clock (rising edge), asynchronous active-low reset
//   h_pos, v_pos                        : scan position from the VGA sync generators
//   wr_valid, wr_ready, wr_addr, wr_data : pixel-write request, buffered in a FIFO
//   wr_err                              : one-cycle pulse when a popped write had an out-of-range address
//   mem_addr, mem_we, mem_wdata         : registered RAM port controls
//   mem_rdata                           : synchronous RAM read data, one-cycle latency
//   pix_data, pix_valid                 : display pixel, three cycles after its scan position
// Define VGA_FB_HBLANK_WRITE_EN to drain writes in every non-active cycle;
// by default writes drain only during vertical blanking.
module vga_fb_arbiter #(
    parameter int COUNTER_SIZE = 11,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    control_clock,
    input  logic                    reset_n,
    input  logic [COUNTER_SIZE-1:0] h_pos,
    input  logic [COUNTER_SIZE-1:0] v_pos,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [DATA_WIDTH-1:0]   pix_data,
    output logic                    pix_valid
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] FB_SIZE = (ADDR_WIDTH+1)'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  bad_q, bad_d;
    logic [1:0]            act_pipe_q;
    logic                  pix_valid_q;
    logic [DATA_WIDTH-1:0] pix_data_q;
    logic                  active, drain_ok, full, empty, push, pop, head_ok;
    logic [ADDR_WIDTH-1:0] fetch_addr, head_addr;

    assign active = (h_pos < COUNTER_SIZE'(H_ACTIVE)) && (v_pos < COUNTER_SIZE'(V_ACTIVE));
`ifdef VGA_FB_HBLANK_WRITE_EN
    assign drain_ok = 1'b1;
`else
    assign drain_ok = v_pos >= COUNTER_SIZE'(V_ACTIVE);
`endif

    assign full       = cnt_q == (PW+1)'(FIFO_DEPTH);
    assign empty      = cnt_q == '0;
    // Held low while in reset so no request is accepted into a FIFO being cleared
    assign wr_ready   = reset_n && !full;
    assign push       = wr_valid && wr_ready;
    assign pop        = state_d == WRITE;
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_ok    = {1'b0, head_addr} < FB_SIZE;
    assign fetch_addr = ADDR_WIDTH'(v_pos) * ADDR_WIDTH'(H_ACTIVE) + ADDR_WIDTH'(h_pos);

    // Port owner for the next cycle; display always wins over draining
    always_comb begin
        state_d = IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bad_d   = 1'b0;
        if (active) begin
            state_d = FETCH;
            addr_d  = fetch_addr;
        end else if (drain_ok && !empty) begin
            state_d = WRITE;
            bad_d   = !head_ok;
            addr_d  = head_ok ? head_addr : addr_q;
            wdata_d = head_ok ? fifo_data_q[rd_ptr_q] : wdata_q;
        end
    end

    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            bad_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            act_pipe_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bad_q       <= bad_d;
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            cnt_q       <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
            act_pipe_q  <= {act_pipe_q[0], active};
            pix_valid_q <= act_pipe_q[1];
            pix_data_q  <= act_pipe_q[1] ? mem_rdata : '0;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge control_clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    // A popped entry drives either a RAM write or the error pulse, never both
    assign mem_we    = (state_q == WRITE) && !bad_q;
    assign wr_err    = (state_q == WRITE) && bad_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: self-checking bench for vga_fb_arbiter with a RAM model and a queue-based reference
module tb_vga_fb_arbiter;
    localparam int FB = 640 * 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] h_pos = '0, v_pos = '0;
    logic        wr_valid = 1'b0, wr_ready, wr_err, mem_we, pix_valid;
    logic [18:0] wr_addr = '0, mem_addr;
    logic [7:0]  wr_data = '0, mem_wdata, mem_rdata = '0, pix_data;

    vga_fb_arbiter dut (
        .control_clock(clk), .reset_n(rst_n), .h_pos(h_pos), .v_pos(v_pos),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
    );

    initial forever #5 clk = ~clk;

    // Synchronous RAM; unwritten locations read back addr[7:0]
    bit [7:0] ram [FB];
    bit       wrote [FB];
    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < FB) begin
            ram[mem_addr]   <= mem_wdata;
            wrote[mem_addr] <= 1'b1;
        end
        mem_rdata <= (int'(mem_addr) >= FB) ? 8'h00 : wrote[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
        end
    endtask

    // Reference: FIFO as a queue of pending writes, expected framebuffer as an array,
    // pixel expectations as a queue delayed by the pipeline depth (-1 = no pixel)
    typedef struct { int a; int d; } wr_t;
    wr_t      fq [$];
    int       pq [$];
    bit [7:0] e_ram [FB];
    bit       e_set [FB];
    bit       e_we, e_err, e_known;
    int       e_addr, e_wdata, e_pix;

    task automatic model_reset;
        fq.delete();
        pq.delete();
        pq.push_back(-1);
        pq.push_back(-1);
        e_we = 0; e_err = 0; e_known = 1; e_addr = 0; e_wdata = 0; e_pix = -1;
    endtask

    task automatic model_step;
        int  h, v, cur;
        bit  act, drain, rdy;
        wr_t e, n;
        h = int'(h_pos);
        v = int'(v_pos);
        cur = -1;
        act = h < 640 && v < 480;
`ifdef VGA_FB_HBLANK_WRITE_EN
        drain = 1;
`else
        drain = v >= 480;
`endif
        rdy = fq.size() < 4;
        e_we = 0;
        e_err = 0;
        if (act) begin
            e_addr = v * 640 + h;
            e_known = 1;
            cur = e_set[e_addr] ? int'(e_ram[e_addr]) : e_addr % 256;
        end else if (drain && fq.size() > 0) begin
            e = fq.pop_front();
            if (e.a < FB) begin
                e_we = 1; e_addr = e.a; e_wdata = e.d; e_known = 1;
                e_ram[e.a] = 8'(e.d);
                e_set[e.a] = 1;
            end else begin
                e_err = 1;
                e_known = 0;
            end
        end
        if (wr_valid && rdy) begin
            n.a = int'(wr_addr);
            n.d = int'(wr_data);
            fq.push_back(n);
        end
        pq.push_back(cur);
        e_pix = pq.pop_front();
    endtask

    task automatic model_compare;
        chk("mon_ready", int'(wr_ready), int'(fq.size() < 4));
        chk("mon_we", int'(mem_we), int'(e_we));
        chk("mon_err", int'(wr_err), int'(e_err));
        if (e_known) chk("mon_addr", int'(mem_addr), e_addr);
        if (e_we) chk("mon_wdata", int'(mem_wdata), e_wdata);
        chk("mon_pvalid", int'(pix_valid), int'(e_pix >= 0));
        chk("mon_pdata", int'(pix_data), e_pix >= 0 ? e_pix : 0);
    endtask

    // One clock cycle: check last edge's outputs, then drive this cycle's inputs
    task automatic cyc(input int h, input int v, input bit val = 0, input int a = 0,
                       input int d = 0, input bit rel = 0);
        @(negedge clk);
        #1;
        if (rst_n) model_compare();
        h_pos = 11'(h); v_pos = 11'(v); wr_valid = val; wr_addr = 19'(a); wr_data = 8'(d);
        if (rel) rst_n = 1'b1;
        if (rst_n) model_step(); else model_reset();
    endtask

    typedef struct { int h; int v; int addr; int pix; } vec_t;
    vec_t tbl [6];
    int   cnt_a, cnt_b, rv, rh;

    initial begin
        tbl[0] = '{100, 2, 1380, 'h64};
        tbl[1] = '{0, 0, 0, 'h00};
        tbl[2] = '{639, 479, 307199, 'hFF};
        tbl[3] = '{639, 0, 639, 'h7F};
        tbl[4] = '{0, 1, 640, 'h80};
        tbl[5] = '{320, 240, 153920, 'h40};

        #1 rst_n = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        #1;
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        chk("rst_pvalid", int'(pix_valid), 0);
        chk("rst_pdata", int'(pix_data), 0);
        chk("rst_err", int'(wr_err), 0);

        // Release with scan at (0,0) and sweep one full line
        cyc(0, 0, 0, 0, 0, 1);
        #1 chk("rel_ready", int'(wr_ready), 1);
        for (int i = 1; i <= 645; i++) begin
            cyc(i < 640 ? i : 700, 0);
            if (i == 2 || i == 643) chk("line_pvalid_off", int'(pix_valid), 0);
            if (i >= 3 && i <= 642) begin
                chk("line_pvalid", int'(pix_valid), 1);
                chk("line_pdata", int'(pix_data), (i - 3) % 256);
            end
        end

        // Fetch address and pixel for fixed positions
        foreach (tbl[k]) begin
            cyc(tbl[k].h, tbl[k].v);
            cyc(tbl[k].h, tbl[k].v);
            chk("vec_addr", int'(mem_addr), tbl[k].addr);
            chk("vec_we", int'(mem_we), 0);
            cyc(tbl[k].h, tbl[k].v);
            cyc(tbl[k].h, tbl[k].v);
            chk("vec_pvalid", int'(pix_valid), 1);
            chk("vec_pdata", int'(pix_data), tbl[k].pix);
        end

        // Fill the FIFO during active video, extra request while full is refused
        for (int k = 0; k < 4; k++) cyc(5, 10, 1, 10 + k, 'hA0 + k);
        cyc(5, 10, 1, 99, 'hEE);
        chk("full_ready", int'(wr_ready), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(5, 10, 1, 99, 'hEE);
            chk("active_no_we", int'(mem_we), 0);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(0, 480);
            if (k >= 1 && k <= 4) begin
                chk("drain_we", int'(mem_we), 1);
                chk("drain_addr", int'(mem_addr), 10 + k - 1);
                chk("drain_data", int'(mem_wdata), 'hA0 + k - 1);
                chk("drain_ready", int'(wr_ready), 1);
            end
            if (k == 5) chk("drain_done", int'(mem_we), 0);
        end

        // Out-of-range write is dropped with one wr_err pulse, next entry commits
        cyc(0, 480, 1, 307200, 'h55);
        cyc(0, 480, 1, 20, 'h66);
        chk("err_idle", int'(wr_err), 0);
        cyc(0, 480);
        chk("err_pulse", int'(wr_err), 1);
        chk("err_no_we", int'(mem_we), 0);
        cyc(0, 480);
        chk("err_next_we", int'(mem_we), 1);
        chk("err_next_addr", int'(mem_addr), 20);
        chk("err_next_data", int'(mem_wdata), 'h66);
        chk("err_once", int'(wr_err), 0);
        cyc(0, 480);
        chk("err_quiet", int'(wr_err) + int'(mem_we), 0);

        // Write issued in horizontal blanking of a visible line
        cyc(700, 5, 1, 30, 'h77);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(700, 5);
            cnt_a += int'(mem_we);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 480);
            cnt_b += int'(mem_we);
        end
`ifdef VGA_FB_HBLANK_WRITE_EN
        chk("hblank_writes", cnt_a, 1);
        chk("vblank_writes", cnt_b, 0);
`else
        chk("hblank_writes", cnt_a, 0);
        chk("vblank_writes", cnt_b, 1);
`endif

        // Reset in the middle of a drain: pending entries vanish, mem_we drops at once
        for (int k = 0; k < 3; k++) cyc(1, 1, 1, 40 + k, 40 + k);
        cyc(0, 480);
        cyc(0, 480);
        chk("middrain_we", int'(mem_we), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_we", int'(mem_we), 0);
        chk("rst_async_addr", int'(mem_addr), 0);
        chk("rst_async_ready", int'(wr_ready), 0);
        cyc(0, 480);
        cyc(0, 480);
        cyc(0, 480, 0, 0, 0, 1);
        #1 chk("rel2_ready", int'(wr_ready), 1);
        cnt_a = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 480);
            cnt_a += int'(mem_we) + int'(wr_err);
        end
        chk("no_stale_writes", cnt_a, 0);

        // Random positions and writes against the reference model
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 479)) : int'($urandom_range(480, 524));
            rh = int'($urandom_range(0, 799));
            cyc(rh, rv, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 307200 + int'($urandom_range(0, 999)) : int'($urandom_range(0, FB - 1)),
                int'($urandom_range(0, 255)));
        end
        for (int k = 0; k < 10; k++) cyc(0, 480);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
